// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan reader: segment codes,
// blank nibble and the capture FSM state type.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] NIB_BLANK = 4'hF;

  typedef enum logic {
    COLLECT = 1'b0,
    EVAL    = 1'b1
  } state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Active-low segment pattern to BCD nibble. Unknown patterns flag invalid
// and report the blank nibble so the output is never undefined.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] nibble_o,
  output logic       invalid_o
);

  always_comb begin
    nibble_o  = NIB_BLANK;
    invalid_o = 1'b0;
    case (pattern_i)
      SEG_0:     nibble_o = 4'd0;
      SEG_1:     nibble_o = 4'd1;
      SEG_2:     nibble_o = 4'd2;
      SEG_3:     nibble_o = 4'd3;
      SEG_4:     nibble_o = 4'd4;
      SEG_5:     nibble_o = 4'd5;
      SEG_6:     nibble_o = 4'd6;
      SEG_7:     nibble_o = 4'd7;
      SEG_8:     nibble_o = 4'd8;
      SEG_9:     nibble_o = 4'd9;
      SEG_BLANK: nibble_o = NIB_BLANK;
      default:   invalid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Samples a multiplexed active-low seven-segment bus, rebuilds whole frames
// and publishes the digit vector after STABLE_FRAMES identical good frames.
//   state   | meaning
//   COLLECT | qualify anode/segment samples into frame slots, run timeout
//   EVAL    | one cycle: judge the finished frame, update match/publish
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_FRAMES = 2,
  parameter int TIMEOUT_CYC   = 65535
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seven,
  input  logic [NUM_DIGITS-1:0]   an,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    valid,
  output logic                    update,
  output logic                    err
);

  localparam int                     CW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0]          TMAX     = CW'(TIMEOUT_CYC);
  localparam logic [CW-1:0]          CNT_ONE  = CW'(1);
  localparam logic [3:0]             STABLE_M = 4'(STABLE_FRAMES);
  localparam logic [NUM_DIGITS-1:0]  AN_ONE   = NUM_DIGITS'(1);
  localparam logic [4*NUM_DIGITS-1:0] ALL_BLANK = {NUM_DIGITS{NIB_BLANK}};

  state_e                  state_q, state_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [NUM_DIGITS-1:0]   inv_q, inv_d;
  logic [4*NUM_DIGITS-1:0] frame_q, frame_d;
  logic [4*NUM_DIGITS-1:0] prev_q, prev_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic                    bad_q, bad_d;
  logic                    incons_q, incons_d;
  logic [3:0]              match_q, match_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    valid_q, valid_d;
  logic                    update_q, update_d;
  logic                    err_q, err_d;

  logic [3:0]            dec_nib;
  logic                  dec_inv;
  logic [NUM_DIGITS-1:0] an_low;
  logic                  multi_low;
  logic                  one_low;
  logic [NUM_DIGITS-1:0] take;
  logic                  cap_full;

  seg7_pattern_decode u_decode (
    .pattern_i (seven),
    .nibble_o  (dec_nib),
    .invalid_o (dec_inv)
  );

  assign an_low    = ~an;
  assign multi_low = (an_low & (an_low - AN_ONE)) != '0;
  assign one_low   = (an_low != '0) && !multi_low;
  assign take      = (state_q == COLLECT && one_low) ? an_low : '0;
  // The sample arriving this cycle may itself complete the frame; that
  // completion must outrank a timeout landing on the same edge.
  assign cap_full  = &(seen_q | take);

  always_comb begin
    state_d  = state_q;
    seen_d   = seen_q;
    inv_d    = inv_q;
    frame_d  = frame_q;
    prev_d   = prev_q;
    digits_d = digits_q;
    bad_d    = bad_q;
    incons_d = incons_q;
    match_d  = match_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    update_d = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      COLLECT: begin
        if (multi_low) err_d = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (take[i]) begin
            if (seen_q[i] && (frame_q[4*i +: 4] != dec_nib || inv_q[i] != dec_inv))
              incons_d = 1'b1;
            if (dec_inv) bad_d = 1'b1;
            frame_d[4*i +: 4] = dec_nib;
            inv_d[i]          = dec_inv;
            seen_d[i]         = 1'b1;
          end
        end

        if (&seen_q) begin
          state_d = EVAL;
        end else if (cnt_q == TMAX) begin
          if (!cap_full) begin
            seen_d   = '0;
            bad_d    = 1'b0;
            incons_d = 1'b0;
            match_d  = 4'd0;
            valid_d  = 1'b0;
            err_d    = 1'b1;
            cnt_d    = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      EVAL: begin
        state_d  = COLLECT;
        seen_d   = '0;
        cnt_d    = '0;
        bad_d    = 1'b0;
        incons_d = 1'b0;
        if (bad_q || incons_q) begin
          match_d = 4'd0;
          err_d   = 1'b1;
        end else begin
          prev_d = frame_q;
          if (frame_q == prev_q)
            match_d = (match_q >= STABLE_M) ? STABLE_M : match_q + 4'd1;
          else
            match_d = 4'd1;
          if (match_d == STABLE_M) begin
            valid_d  = 1'b1;
            digits_d = frame_q;
            update_d = (frame_q != digits_q) || !valid_q;
          end
        end
      end

      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= COLLECT;
      seen_q   <= '0;
      inv_q    <= '0;
      frame_q  <= ALL_BLANK;
      prev_q   <= ALL_BLANK;
      digits_q <= ALL_BLANK;
      bad_q    <= 1'b0;
      incons_q <= 1'b0;
      match_q  <= 4'd0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      update_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      seen_q   <= seen_d;
      inv_q    <= inv_d;
      frame_q  <= frame_d;
      prev_q   <= prev_d;
      digits_q <= digits_d;
      bad_q    <= bad_d;
      incons_q <= incons_d;
      match_q  <= match_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      update_q <= update_d;
      err_q    <= err_d;
    end
  end

  assign digits = digits_q;
  assign valid  = valid_q;
  assign update = update_q;
  assign err    = err_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed plus randomized frame-level bench for seg7_scan_capture, checked
// against a frame-by-frame reference model of the publish rules.
module tb_seg7_scan_capture;

  localparam int N = 4;
  localparam int S = 2;
  localparam int T = 100;

  logic         clk = 1'b0;
  logic         rst;
  logic [6:0]   seven;
  logic [N-1:0] an;
  logic [4*N-1:0] digits;
  logic         valid, update, err;

  always #5 clk = ~clk;

  seg7_scan_capture #(
    .NUM_DIGITS    (N),
    .STABLE_FRAMES (S),
    .TIMEOUT_CYC   (T)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .seven  (seven),
    .an     (an),
    .digits (digits),
    .valid  (valid),
    .update (update),
    .err    (err)
  );

  int checks = 0;
  int errors = 0;
  int tick_no = 0;
  int upd_cnt, err_cnt, upd_at, last_tick;

  // index 0..9 = digit, index 10 = blank
  logic [6:0] code_tab [0:10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                  7'b0000000, 7'b0000100, 7'b1111111};
  logic [N-1:0] glitch_tab [0:5] = '{4'b0011, 4'b0101, 4'b1001, 4'b0000, 4'b1100, 4'b0110};
  logic [6:0] f_seg [0:N-1];

  logic [4*N-1:0] m_digits, m_prev;
  logic           m_valid;
  int             m_match;

  function automatic logic [4:0] ref_nib(input logic [6:0] s);
    for (int k = 0; k < 11; k++)
      if (code_tab[k] == s) return (k == 10) ? 5'h0F : 5'(k);
    return 5'h1F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [6:0] s, input logic [N-1:0] a);
    seven = s;
    an    = a;
    @(posedge clk);
    @(negedge clk);
    if (update === 1'b1) begin upd_cnt++; upd_at = tick_no; end
    if (err === 1'b1) err_cnt++;
    tick_no++;
  endtask

  function automatic logic [N-1:0] an_sel(input int i);
    logic [N-1:0] one = 1;
    return ~(one << i);
  endfunction

  function automatic logic [6:0] rand_invalid();
    logic [6:0] s;
    s = 7'(($urandom_range(0, 127)));
    while (!ref_nib(s)[4]) s = 7'(($urandom_range(0, 127)));
    return s;
  endfunction

  task automatic model_reset();
    m_digits = {N{4'hF}};
    m_prev   = {N{4'hF}};
    m_valid  = 1'b0;
    m_match  = 0;
  endtask

  // Scan one frame: slots 0..N-2 held 'hold' cycles, the last slot shown for
  // one cycle, then blanking. Optional glitch before a slot and an
  // inconsistent re-sample after a slot.
  task automatic run_frame(input string tag, input int hold, input int glitch_slot,
                           input int incons_slot, input int gap);
    logic [4*N-1:0] fr;
    logic [4:0]     r;
    logic [6:0]     alt;
    bit             bad;
    bit             exp_upd;
    int             exp_err;
    bad = 0; exp_upd = 0; exp_err = 0;
    upd_cnt = 0; err_cnt = 0; upd_at = -1;
    fr = '0;
    for (int i = 0; i < N; i++) begin
      r = ref_nib(f_seg[i]);
      fr[4*i +: 4] = r[3:0];
      if (r[4]) bad = 1;
      if (i == glitch_slot) begin
        tick(7'h00, glitch_tab[$urandom_range(0, 5)]);
        exp_err++;
      end
      if (i == N-1) begin
        tick(f_seg[i], an_sel(i));
        last_tick = tick_no - 1;
      end else begin
        repeat (hold) tick(f_seg[i], an_sel(i));
        if (i == incons_slot) begin
          alt = code_tab[$urandom_range(0, 10)];
          while (alt == f_seg[i]) alt = code_tab[$urandom_range(0, 10)];
          tick(alt, an_sel(i));
          bad = 1;
        end
        repeat (gap) tick(7'h7F, {N{1'b1}});
      end
    end
    repeat (4) tick(7'h7F, {N{1'b1}});

    if (bad) begin
      m_match = 0;
      exp_err++;
    end else begin
      if (m_match > 0 && fr == m_prev) m_match = (m_match + 1 > S) ? S : m_match + 1;
      else m_match = 1;
      m_prev = fr;
      if (m_match == S) begin
        exp_upd  = !m_valid || (m_digits != fr);
        m_valid  = 1'b1;
        m_digits = fr;
      end
    end

    check({tag, "_update"}, upd_cnt, exp_upd ? 1 : 0);
    check({tag, "_err"}, err_cnt, exp_err);
    check({tag, "_digits"}, digits, m_digits);
    check({tag, "_valid"}, valid, m_valid);
    if (exp_upd) check({tag, "_latency"}, upd_at - last_tick, 2);
  endtask

  task automatic set_frame(input int d3, input int d2, input int d1, input int d0);
    f_seg[3] = code_tab[d3];
    f_seg[2] = code_tab[d2];
    f_seg[1] = code_tab[d1];
    f_seg[0] = code_tab[d0];
  endtask

  initial begin
    rst = 1'b1;
    seven = 7'h7F;
    an = {N{1'b1}};
    model_reset();

    repeat (3) tick(7'h7F, {N{1'b1}});
    check("rst_digits", digits, 16'hFFFF);
    check("rst_valid", valid, 0);
    check("rst_update", update, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    set_frame(1, 2, 3, 4);
    run_frame("stable1", 8, -1, -1, 0);
    run_frame("stable2", 8, -1, -1, 0);
    check("stable_value", digits, 16'h1234);
    run_frame("stable3", 8, -1, -1, 0);

    set_frame(1, 2, 3, 5);
    run_frame("change1", 8, -1, -1, 0);
    run_frame("change2", 8, -1, -1, 0);
    check("change_value", digits, 16'h1235);

    f_seg[2] = 7'b1010101;
    run_frame("invalid", 8, -1, -1, 0);
    check("invalid_keep", digits, 16'h1235);
    f_seg[2] = code_tab[2];
    run_frame("repub1", 8, -1, -1, 0);
    run_frame("repub2", 8, -1, -1, 0);

    upd_cnt = 0; err_cnt = 0;
    tick(7'h00, 4'b0011);
    check("glitch_err", err_cnt, 1);
    tick(f_seg[0], an_sel(0));
    tick(f_seg[1], an_sel(1));
    repeat (T + 10) tick(7'h7F, {N{1'b1}});
    m_valid = 1'b0;
    m_match = 0;
    check("timeout_err", err_cnt, 2);
    check("timeout_valid", valid, 0);
    check("timeout_digits", digits, m_digits);
    check("timeout_update", upd_cnt, 0);
    run_frame("after_to1", 6, -1, -1, 1);
    run_frame("after_to2", 6, -1, -1, 1);

    tick(f_seg[0], an_sel(0));
    tick(f_seg[1], an_sel(1));
    rst = 1'b1;
    tick(7'h7F, {N{1'b1}});
    rst = 1'b0;
    model_reset();
    check("midrst_digits", digits, 16'hFFFF);
    check("midrst_valid", valid, 0);
    set_frame(10, 1, 2, 3);
    run_frame("blank1", 5, -1, -1, 0);
    run_frame("blank2", 5, -1, -1, 0);
    check("blank_value", digits, 16'hF123);

    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < N; i++) begin
          int r;
          r = $urandom_range(0, 15);
          if (r < 10)       f_seg[i] = code_tab[r];
          else if (r < 12)  f_seg[i] = code_tab[10];
          else if (r == 12) f_seg[i] = rand_invalid();
          else              f_seg[i] = code_tab[$urandom_range(0, 9)];
        end
      end
      run_frame("rand", $urandom_range(1, 6),
                ($urandom_range(0, 5) == 0) ? $urandom_range(0, N-1) : -1,
                ($urandom_range(0, 7) == 0) ? $urandom_range(0, N-2) : -1,
                $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
